// File: rtl/load_store_unit_if.sv
// Data-memory port between the load/store unit and an 8-byte-wide memory.
// Latency: none, plain wiring bundle.
// Backpressure: req is held until ack; the memory stalls the core by withholding ack.
interface load_store_unit_if;
  logic        req;
  logic        we;
  logic [63:0] addr;
  logic [7:0]  be;
  logic [63:0] wdata;
  logic        ack;
  logic [63:0] rdata;

  modport master (output req, we, addr, be, wdata, input ack, rdata);
  modport slave  (input req, we, addr, be, wdata, output ack, rdata);
endinterface

// File: rtl/load_store_unit.sv
// Load/store stage: issues one req/ack data-memory access per load or store and extends load data.
// Latency: request at T, dmem_req at T+1, earliest done/rdata at T+2; bus error after TIMEOUT_CYCLES BUSY cycles.
// Backpressure: stall holds the core from request acceptance until ack or timeout; misaligned accesses never stall.
module load_store_unit #(
  parameter int unsigned REG_WIDTH      = 64,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  mem_read,
  input  logic                  mem_write,
  input  logic                  mem_sign,
  input  logic [1:0]            mem_width,
  input  logic [REG_WIDTH-1:0]  addr,
  input  logic [REG_WIDTH-1:0]  wdata,
  output logic                  stall,
  output logic                  misaligned,
  output logic [REG_WIDTH-1:0]  rdata,
  output logic                  done,
  output logic                  bus_err,
  load_store_unit_if.master     dmem
);

  localparam int unsigned TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TLAST = TW'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;

  state_t        state, state_nxt;
  logic [TW-1:0] tcnt;
  logic [2:0]    off_q;
  logic [1:0]    width_q;
  logic          sign_q;
  logic          is_rd_q;

  logic          acc;
  logic          mis;
  logic          timeout;
  logic [2:0]    size_mask;
  logic [7:0]    be_base;
  logic [63:0]   rd_shift;
  logic [63:0]   rd_ext;

  // Decode the access: alignment mask, unshifted byte enables and misalignment.
  always_comb begin
    acc       = mem_read | mem_write;
    size_mask = 3'b000;
    be_base   = 8'h01;
    case (mem_width)
      2'd0: begin size_mask = 3'b000; be_base = 8'h01; end
      2'd1: begin size_mask = 3'b001; be_base = 8'h03; end
      2'd2: begin size_mask = 3'b011; be_base = 8'h0F; end
      default: begin size_mask = 3'b111; be_base = 8'hFF; end
    endcase
    mis     = acc & (|(addr[2:0] & size_mask));
    timeout = (TIMEOUT_CYCLES != 0) && (tcnt == TLAST);
  end

  // Align the returned lane to bit 0 and extend it using the width/sign captured at issue.
  always_comb begin
    rd_shift = dmem.rdata >> {off_q, 3'b000};
    rd_ext   = rd_shift;
    case (width_q)
      2'd0: rd_ext = sign_q ? {56'd0, rd_shift[7:0]}  : {{56{rd_shift[7]}},  rd_shift[7:0]};
      2'd1: rd_ext = sign_q ? {48'd0, rd_shift[15:0]} : {{48{rd_shift[15]}}, rd_shift[15:0]};
      2'd2: rd_ext = sign_q ? {32'd0, rd_shift[31:0]} : {{32{rd_shift[31]}}, rd_shift[31:0]};
      default: rd_ext = rd_shift;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next state plus the combinational stall and misaligned flags.
  always_comb begin
    state_nxt  = state;
    stall      = 1'b0;
    misaligned = 1'b0;
    case (state)
      IDLE: begin
        misaligned = mis;
        stall      = acc & ~mis;
        if (acc && !mis) state_nxt = BUSY;
      end
      BUSY: begin
        stall = 1'b1;
        if (dmem.ack || timeout) state_nxt = DONE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Bus outputs, result register and timeout counter; ack only has effect in BUSY.
  always_ff @(posedge clk) begin
    if (rst) begin
      dmem.req   <= 1'b0;
      dmem.we    <= 1'b0;
      dmem.addr  <= '0;
      dmem.be    <= '0;
      dmem.wdata <= '0;
      rdata      <= '0;
      done       <= 1'b0;
      bus_err    <= 1'b0;
      tcnt       <= '0;
      off_q      <= '0;
      width_q    <= '0;
      sign_q     <= 1'b0;
      is_rd_q    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (acc && !mis) begin
            dmem.req   <= 1'b1;
            dmem.we    <= mem_write & ~mem_read;
            dmem.addr  <= {addr[63:3], 3'b000};
            dmem.be    <= be_base << addr[2:0];
            dmem.wdata <= wdata << {addr[2:0], 3'b000};
            off_q      <= addr[2:0];
            width_q    <= mem_width;
            sign_q     <= mem_sign;
            is_rd_q    <= mem_read;
            tcnt       <= '0;
          end
        end
        BUSY: begin
          tcnt <= tcnt + 1'b1;
          if (dmem.ack) begin
            dmem.req <= 1'b0;
            if (is_rd_q) rdata <= rd_ext;
            done    <= 1'b1;
            bus_err <= 1'b0;
          end else if (timeout) begin
            dmem.req <= 1'b0;
            rdata    <= '0;
            done     <= 1'b1;
            bus_err  <= 1'b1;
          end
        end
        default: begin
          done <= 1'b0;
          tcnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;
  logic        clk = 1'b0;
  logic        rst;
  logic        mem_read, mem_write, mem_sign;
  logic [1:0]  mem_width;
  logic [63:0] addr, wdata;
  logic        stall, misaligned, done, bus_err;
  logic [63:0] rdata;
  int total = 0;
  int bad   = 0;

  load_store_unit_if bus();

  load_store_unit #(.REG_WIDTH(64), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst(rst),
    .mem_read(mem_read), .mem_write(mem_write), .mem_sign(mem_sign),
    .mem_width(mem_width), .addr(addr), .wdata(wdata),
    .stall(stall), .misaligned(misaligned), .rdata(rdata),
    .done(done), .bus_err(bus_err), .dmem(bus)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs;
    mem_read = 0; mem_write = 0; mem_sign = 0; mem_width = 0;
    addr = 0; wdata = 0; bus.ack = 0; bus.rdata = 0;
  endtask

  task automatic test_reset;
    rst = 1; clear_inputs();
    tick(); tick();
    total++; if (bus.req !== 1'b0) begin bad++; $display("FAIL reset_req got=%b want=0", bus.req); end
    total++; if ({bus.we, bus.be} !== 9'd0) begin bad++; $display("FAIL reset_we_be got=%h want=0", {bus.we, bus.be}); end
    total++; if ({bus.addr, bus.wdata} !== 128'd0) begin bad++; $display("FAIL reset_addr_wdata got=%h want=0", {bus.addr, bus.wdata}); end
    total++; if ({rdata, done, bus_err} !== 66'd0) begin bad++; $display("FAIL reset_rdata_done_err got=%h want=0", {rdata, done, bus_err}); end
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL reset_stall got=%b want=0", stall); end
    rst = 0;
    tick();
  endtask

  task automatic test_load(input string nm, input logic [63:0] a, input logic [1:0] w, input logic s,
                           input logic [63:0] bus_data, input logic [63:0] exp_addr,
                           input logic [7:0] exp_be, input logic [63:0] exp_rd);
    mem_read = 1; mem_width = w; mem_sign = s; addr = a;
    #1;
    total++; if (stall !== 1'b1) begin bad++; $display("FAIL %s_stall_idle got=%b want=1", nm, stall); end
    tick();
    total++; if (bus.req !== 1'b1 || bus.we !== 1'b0) begin bad++; $display("FAIL %s_req_we got=%b%b want=10", nm, bus.req, bus.we); end
    total++; if (bus.addr !== exp_addr) begin bad++; $display("FAIL %s_addr got=%h want=%h", nm, bus.addr, exp_addr); end
    total++; if (bus.be !== exp_be) begin bad++; $display("FAIL %s_be got=%h want=%h", nm, bus.be, exp_be); end
    bus.ack = 1; bus.rdata = bus_data;
    #1;
    total++; if (stall !== 1'b1) begin bad++; $display("FAIL %s_stall_busy got=%b want=1", nm, stall); end
    tick();
    bus.ack = 0;
    total++; if (done !== 1'b1 || bus_err !== 1'b0) begin bad++; $display("FAIL %s_done_err got=%b%b want=10", nm, done, bus_err); end
    total++; if (rdata !== exp_rd) begin bad++; $display("FAIL %s_rdata got=%h want=%h", nm, rdata, exp_rd); end
    total++; if (bus.req !== 1'b0 || stall !== 1'b0) begin bad++; $display("FAIL %s_done_req_stall got=%b%b want=00", nm, bus.req, stall); end
    mem_read = 0;
    tick();
    total++; if (done !== 1'b0) begin bad++; $display("FAIL %s_done_clear got=%b want=0", nm, done); end
  endtask

  task automatic test_store_half;
    int stalls;
    logic [63:0] prev_rd;
    prev_rd = rdata;
    stalls = 0;
    mem_write = 1; mem_width = 1; addr = 64'h2006; wdata = 64'h1234;
    #1; if (stall === 1'b1) stalls++;
    tick(); if (stall === 1'b1) stalls++;
    total++; if (bus.req !== 1'b1 || bus.we !== 1'b1) begin bad++; $display("FAIL st_req_we got=%b%b want=11", bus.req, bus.we); end
    total++; if (bus.be !== 8'hC0) begin bad++; $display("FAIL st_be got=%h want=c0", bus.be); end
    total++; if (bus.wdata !== 64'h1234_0000_0000_0000) begin bad++; $display("FAIL st_wdata got=%h want=1234000000000000", bus.wdata); end
    total++; if (bus.addr !== 64'h2000) begin bad++; $display("FAIL st_addr got=%h want=2000", bus.addr); end
    tick(); if (stall === 1'b1) stalls++;
    total++; if (bus.req !== 1'b1 || bus.be !== 8'hC0 || bus.wdata !== 64'h1234_0000_0000_0000) begin
      bad++; $display("FAIL st_stable got=%b/%h/%h want=1/c0/1234000000000000", bus.req, bus.be, bus.wdata); end
    tick();
    bus.ack = 1;
    #1; if (stall === 1'b1) stalls++;
    tick();
    bus.ack = 0; mem_write = 0;
    #1; if (stall === 1'b1) stalls++;
    total++; if (stalls !== 4) begin bad++; $display("FAIL st_stall_cycles got=%0d want=4", stalls); end
    total++; if (done !== 1'b1 || bus_err !== 1'b0) begin bad++; $display("FAIL st_done_err got=%b%b want=10", done, bus_err); end
    total++; if (rdata !== prev_rd) begin bad++; $display("FAIL st_rdata_kept got=%h want=%h", rdata, prev_rd); end
    tick();
  endtask

  task automatic test_misaligned;
    int mis_cnt, stall_cnt, req_cnt;
    mis_cnt = 0; stall_cnt = 0; req_cnt = 0;
    mem_read = 1; mem_width = 2; addr = 64'h3002;
    for (int i = 0; i < 4; i++) begin
      #1;
      if (misaligned === 1'b1) mis_cnt++;
      if (stall !== 1'b0) stall_cnt++;
      if (bus.req !== 1'b0) req_cnt++;
      tick();
    end
    total++; if (mis_cnt !== 4) begin bad++; $display("FAIL mis_flag got=%0d want=4", mis_cnt); end
    total++; if (stall_cnt !== 0) begin bad++; $display("FAIL mis_stall got=%0d want=0", stall_cnt); end
    total++; if (req_cnt !== 0 || done !== 1'b0) begin bad++; $display("FAIL mis_req_done got=%0d/%b want=0/0", req_cnt, done); end
    mem_read = 0;
    #1;
    total++; if (misaligned !== 1'b0) begin bad++; $display("FAIL mis_idle_clear got=%b want=0", misaligned); end
    tick();
  endtask

  task automatic test_timeout;
    int req_cnt;
    bit seen;
    req_cnt = 0; seen = 0;
    mem_read = 1; mem_width = 3; addr = 64'h5000;
    tick();
    for (int i = 0; i < 40; i++) begin
      if (done === 1'b1) begin seen = 1; break; end
      if (bus.req === 1'b1) req_cnt++;
      tick();
    end
    mem_read = 0;
    total++; if (!seen) begin bad++; $display("FAIL to_done_seen got=0 want=1"); end
    total++; if (req_cnt !== 16) begin bad++; $display("FAIL to_req_cycles got=%0d want=16", req_cnt); end
    total++; if (bus_err !== 1'b1 || rdata !== 64'd0) begin bad++; $display("FAIL to_err_rdata got=%b/%h want=1/0", bus_err, rdata); end
    tick();
  endtask

  task automatic test_back_to_back;
    mem_read = 1; mem_width = 3; addr = 64'h4000;
    tick();
    bus.ack = 1; bus.rdata = 64'h1122_3344_5566_7788;
    total++; if (bus.req !== 1'b1 || bus.be !== 8'hFF) begin bad++; $display("FAIL b2b_ld_req_be got=%b/%h want=1/ff", bus.req, bus.be); end
    tick();
    bus.ack = 0;
    total++; if (done !== 1'b1 || rdata !== 64'h1122_3344_5566_7788) begin bad++; $display("FAIL b2b_ld_done got=%b/%h want=1/1122334455667788", done, rdata); end
    mem_read = 0; mem_write = 1; mem_width = 2; addr = 64'h4004; wdata = 64'hCAFE_BABE;
    #1;
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL b2b_done_stall got=%b want=0", stall); end
    tick();
    total++; if (bus.req !== 1'b0 || stall !== 1'b1) begin bad++; $display("FAIL b2b_idle_req_stall got=%b%b want=01", bus.req, stall); end
    tick();
    total++; if (bus.req !== 1'b1 || bus.we !== 1'b1 || bus.be !== 8'hF0) begin bad++; $display("FAIL b2b_st_req got=%b/%b/%h want=1/1/f0", bus.req, bus.we, bus.be); end
    total++; if (bus.wdata !== 64'hCAFE_BABE_0000_0000 || bus.addr !== 64'h4000) begin bad++; $display("FAIL b2b_st_bus got=%h/%h want=cafebabe00000000/4000", bus.wdata, bus.addr); end
    bus.ack = 1;
    tick();
    bus.ack = 0; mem_write = 0;
    total++; if (done !== 1'b1 || rdata !== 64'h1122_3344_5566_7788) begin bad++; $display("FAIL b2b_st_done got=%b/%h want=1/1122334455667788", done, rdata); end
    tick();
  endtask

  task automatic test_reset_in_busy;
    int done_cnt;
    done_cnt = 0;
    mem_read = 1; mem_width = 3; addr = 64'h6000;
    tick();
    tick();
    total++; if (bus.req !== 1'b1) begin bad++; $display("FAIL rb_busy_req got=%b want=1", bus.req); end
    rst = 1; mem_read = 0;
    tick();
    rst = 0;
    total++; if (bus.req !== 1'b0 || bus.be !== 8'd0 || bus.addr !== 64'd0) begin bad++; $display("FAIL rb_bus_reset got=%b/%h/%h want=0/0/0", bus.req, bus.be, bus.addr); end
    total++; if (rdata !== 64'd0 || bus_err !== 1'b0) begin bad++; $display("FAIL rb_rdata_err got=%h/%b want=0/0", rdata, bus_err); end
    bus.ack = 1; bus.rdata = 64'hDEAD_BEEF_DEAD_BEEF;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (done !== 1'b0 || stall !== 1'b0) done_cnt++;
    end
    bus.ack = 0;
    total++; if (done_cnt !== 0 || rdata !== 64'd0) begin bad++; $display("FAIL rb_late_ack got=%0d/%h want=0/0", done_cnt, rdata); end
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1;
    clear_inputs();
    test_reset();
    test_load("lb_s", 64'h1005, 2'd0, 1'b0, 64'h0000_80FF_0000_0000, 64'h1000, 8'h20, 64'hFFFF_FFFF_FFFF_FF80);
    test_load("lb_u", 64'h1005, 2'd0, 1'b1, 64'h0000_80FF_0000_0000, 64'h1000, 8'h20, 64'h0000_0000_0000_0080);
    test_load("lh_s", 64'h1002, 2'd1, 1'b0, 64'h0000_0000_9ABC_0000, 64'h1000, 8'h0C, 64'hFFFF_FFFF_FFFF_9ABC);
    test_load("lw_s", 64'h7004, 2'd2, 1'b0, 64'h8000_0001_0000_0000, 64'h7000, 8'hF0, 64'hFFFF_FFFF_8000_0001);
    test_store_half();
    test_misaligned();
    test_timeout();
    test_back_to_back();
    test_reset_in_busy();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
